// File: rtl/comb_sweep_pkg.sv
// Shared types, MISR constants and MISR step function for the comb_sweep block.
package comb_sweep_pkg;

  localparam int unsigned SIG_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
  localparam logic [SIG_W-1:0] MISR_SEED = 16'hFFFF;

  // Shift-left LFSR with feedback on the MSB, then fold in the data word.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] data);
    logic [SIG_W-1:0] shifted;
    shifted = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0);
    return shifted ^ data;
  endfunction

endpackage

// File: rtl/comb_sweep_ctrl_if.sv
// Truth-table row stream: one captured DUT output word per input vector.
interface comb_sweep_ctrl_if #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 4
);
  logic             tt_valid;
  logic             tt_ready;
  logic [N_IN-1:0]  tt_index;
  logic [N_OUT-1:0] tt_data;

  modport master (output tt_valid, output tt_index, output tt_data, input tt_ready);
  modport slave  (input tt_valid, input tt_index, input tt_data, output tt_ready);
endinterface

// File: rtl/comb_sweep_misr.sv
// 16-bit MISR register: seed load has priority over a step.
module comb_sweep_misr
  import comb_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_en,
  input  logic             step_en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] sig_q;

  always_comb begin
    sig_d = sig_q;
    if (seed_en) begin
      sig_d = MISR_SEED;
    end else if (step_en) begin
      sig_d = misr_step(sig_q, data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Exhaustive sweep sequencer for a small combinational netlist: drives every input
// vector, streams captured rows and folds them into a MISR. COMB_SWEEP_EQUIV_EN adds a
// reference-netlist compare (mismatch / first_bad_idx).
module comb_sweep_ctrl
  import comb_sweep_pkg::*;
#(
  parameter int unsigned N_IN       = 3,
  parameter int unsigned N_OUT      = 4,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [N_IN-1:0]      dut_in,
  input  logic [N_OUT-1:0]     dut_out,
  comb_sweep_ctrl_if.master    tt,
  output logic [SIG_W-1:0]     signature
`ifdef COMB_SWEEP_EQUIV_EN
  ,
  input  logic [N_OUT-1:0]     dut_ref_out,
  output logic                 mismatch,
  output logic [N_IN-1:0]      first_bad_idx
`endif
);

  // One extra index bit so the last-vector compare never wraps.
  localparam int unsigned      IDX_W    = N_IN + 1;
  localparam int unsigned      CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << N_IN) - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  state_e             state_d,    state_q;
  logic [IDX_W-1:0]   idx_d,      idx_q;
  logic [CNT_W-1:0]   cnt_d,      cnt_q;
  logic               busy_d,     busy_q;
  logic               done_d,     done_q;
  logic               aborted_d,  aborted_q;
  logic [N_IN-1:0]    dut_in_d,   dut_in_q;
  logic               tt_valid_d, tt_valid_q;
  logic [N_IN-1:0]    tt_index_d, tt_index_q;
  logic [N_OUT-1:0]   tt_data_d,  tt_data_q;
  logic               seed_en;
  logic               step_en;

  // Next-state and registered-output logic; abort overrides every transition.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    tt_valid_d = tt_valid_q;
    tt_index_d = tt_index_q;
    tt_data_d  = tt_data_q;
    seed_en    = 1'b0;
    step_en    = 1'b0;

    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      tt_valid_d = 1'b0;
      aborted_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = APPLY;
            idx_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            seed_en = 1'b1;
          end
        end
        APPLY: begin
          if (cnt_q == CNT_LAST) begin
            state_d    = EMIT;
            tt_valid_d = 1'b1;
            tt_index_d = idx_q[N_IN-1:0];
            tt_data_d  = dut_out;
            step_en    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        EMIT: begin
          if (tt_valid_q && tt.tt_ready) begin
            tt_valid_d = 1'b0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = APPLY;
              idx_d   = idx_q + IDX_W'(1);
              cnt_d   = '0;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    dut_in_d = (state_d == IDLE) ? '0 : idx_d[N_IN-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      dut_in_q   <= '0;
      tt_valid_q <= 1'b0;
      tt_index_q <= '0;
      tt_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      dut_in_q   <= dut_in_d;
      tt_valid_q <= tt_valid_d;
      tt_index_q <= tt_index_d;
      tt_data_q  <= tt_data_d;
    end
  end

  comb_sweep_misr u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .seed_en (seed_en),
    .step_en (step_en),
    .data    (SIG_W'(dut_out)),
    .sig     (signature)
  );

`ifdef COMB_SWEEP_EQUIV_EN
  logic            mismatch_d,      mismatch_q;
  logic [N_IN-1:0] first_bad_idx_d, first_bad_idx_q;

  // Sticky compare against the reference netlist at capture; cleared on start.
  always_comb begin
    mismatch_d      = mismatch_q;
    first_bad_idx_d = first_bad_idx_q;
    if (seed_en) begin
      mismatch_d      = 1'b0;
      first_bad_idx_d = '0;
    end else if (step_en && !mismatch_q && (dut_out != dut_ref_out)) begin
      mismatch_d      = 1'b1;
      first_bad_idx_d = idx_q[N_IN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_q      <= 1'b0;
      first_bad_idx_q <= '0;
    end else begin
      mismatch_q      <= mismatch_d;
      first_bad_idx_q <= first_bad_idx_d;
    end
  end

  assign mismatch      = mismatch_q;
  assign first_bad_idx = first_bad_idx_q;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign dut_in      = dut_in_q;
  assign tt.tt_valid = tt_valid_q;
  assign tt.tt_index = tt_index_q;
  assign tt.tt_data  = tt_data_q;

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Bench for comb_sweep_ctrl: truth-table DUT model, randomized tables and stalls,
// reference MISR computed arithmetically.
module tb_comb_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [2:0]  dut_in;
  logic [3:0]  dut_out;
  logic [15:0] signature;
  logic [3:0]  tab [8];
  int          cyc;
  int          checks;
  int          failures;
  int          s_part;

  comb_sweep_ctrl_if #(.N_IN(3), .N_OUT(4)) tif ();

`ifdef COMB_SWEEP_EQUIV_EN
  logic [3:0] ref_tab [8];
  logic [3:0] dut_ref_out;
  logic       mismatch;
  logic [2:0] first_bad_idx;
  assign dut_ref_out = ref_tab[dut_in];
`endif

  assign dut_out = tab[dut_in];

  comb_sweep_ctrl #(.N_IN(3), .N_OUT(4), .SETTLE_CYC(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .dut_in        (dut_in),
    .dut_out       (dut_out),
    .tt            (tif.master),
    .signature     (signature)
`ifdef COMB_SWEEP_EQUIV_EN
    ,
    .dut_ref_out   (dut_ref_out),
    .mismatch      (mismatch),
    .first_bad_idx (first_bad_idx)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int misr_ref(input int s, input int d);
    int fb;
    fb = (s >> 15) & 1;
    s  = (s * 2) % 65536;
    if (fb != 0) s = s ^ 'h1021;
    return s ^ d;
  endfunction

  task automatic wait_valid();
    int n = 0;
    while (tif.tt_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("wait_valid", 32'(tif.tt_valid), 32'd1);
  endtask

  task automatic randomize_tab();
    for (int i = 0; i < 8; i++) tab[i] = 4'($urandom);
  endtask

  task automatic sync_ref();
`ifdef COMB_SWEEP_EQUIV_EN
    for (int i = 0; i < 8; i++) ref_tab[i] = tab[i];
`endif
  endtask

  // Full sweep with an optional stall on one row; returns the final expected signature.
  task automatic sweep(input int stall_row, input int stall_len, input bit with_abort,
                       output int s);
    int acc;
    int stalled;
    s       = 'hFFFF;
    stalled = 0;
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    acc   = cyc;
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_aborted", 32'(aborted), 32'd0);
    check("acc_seed", 32'(signature), 32'hFFFF);
`ifdef COMB_SWEEP_EQUIV_EN
    check("eq_clear_mm", 32'(mismatch), 32'd0);
    check("eq_clear_idx", 32'(first_bad_idx), 32'd0);
`endif
    for (int r = 0; r < 8; r++) begin
      wait_valid();
      check("row_time", 32'(cyc - acc), 32'(2 * r + 1 + stalled));
      check("row_index", 32'(tif.tt_index), 32'(r));
      check("row_data", 32'(tif.tt_data), 32'(tab[r]));
      check("row_dut_in", 32'(dut_in), 32'(r));
      s = misr_ref(s, int'(tab[r]));
      check("row_sig", 32'(signature), 32'(s));
      if (r == stall_row) begin
        tif.tt_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          check("hold_valid", 32'(tif.tt_valid), 32'd1);
          check("hold_index", 32'(tif.tt_index), 32'(r));
          check("hold_data", 32'(tif.tt_data), 32'(tab[r]));
          check("hold_dut_in", 32'(dut_in), 32'(r));
          check("hold_sig", 32'(signature), 32'(s));
        end
        stalled += stall_len;
        tif.tt_ready = 1'b1;
      end
      tick();
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_time", 32'(cyc - acc), 32'(16 + stalled));
    check("done_busy", 32'(busy), 32'd0);
    check("done_valid", 32'(tif.tt_valid), 32'd0);
    check("done_dut_in", 32'(dut_in), 32'd7);
    check("done_sig", 32'(signature), 32'(s));
    tick();
    check("idle_done", 32'(done), 32'd0);
    check("idle_dut_in", 32'(dut_in), 32'd0);
    check("idle_sig_hold", 32'(signature), 32'(s));
    check("idle_aborted", 32'(aborted), 32'd0);
`ifdef COMB_SWEEP_EQUIV_EN
    begin
      int first = -1;
      for (int i = 0; i < 8; i++) if (first < 0 && tab[i] != ref_tab[i]) first = i;
      check("eq_mismatch", 32'(mismatch), (first >= 0) ? 32'd1 : 32'd0);
      check("eq_first_bad", 32'(first_bad_idx), (first >= 0) ? 32'(first) : 32'd0);
    end
`endif
  endtask

  initial begin
    int s;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    tif.tt_ready = 1'b1;
    for (int i = 0; i < 8; i++) tab[i] = 4'd0;
    sync_ref();
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_valid", 32'(tif.tt_valid), 32'd0);
    check("rst_dut_in", 32'(dut_in), 32'd0);
    check("rst_index", 32'(tif.tt_index), 32'd0);
    check("rst_data", 32'(tif.tt_data), 32'd0);
    check("rst_sig", 32'(signature), 32'hFFFF);
    rst_n = 1'b1;
    tick();

    // All-zero responses: known signature.
    sweep(-1, 0, 1'b0, s);
    check("zero_sig", 32'(signature), 32'hE1F0);

    // Identity responses.
    for (int i = 0; i < 8; i++) tab[i] = 4'(i);
    sync_ref();
    sweep(-1, 0, 1'b0, s);

    // Consumer stall on row 3 for 5 cycles.
    randomize_tab();
    sync_ref();
    sweep(3, 5, 1'b0, s);

    // Random stall; start and abort together in IDLE.
    randomize_tab();
    sync_ref();
    sweep(int'($urandom_range(0, 7)), int'($urandom_range(1, 6)), 1'b1, s);

    // Abort during APPLY of vector 5.
    randomize_tab();
    sync_ref();
    s_part = 'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 5; r++) begin
      wait_valid();
      s_part = misr_ref(s_part, int'(tab[r]));
      tick();
    end
    check("ab_apply_dut_in", 32'(dut_in), 32'd5);
    check("ab_apply_valid", 32'(tif.tt_valid), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_pulse", 32'(aborted), 32'd1);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_valid", 32'(tif.tt_valid), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    check("ab_dut_in", 32'(dut_in), 32'd0);
    check("ab_sig_partial", 32'(signature), 32'(s_part));
    tick();
    check("ab_pulse_end", 32'(aborted), 32'd0);
    check("ab_no_done", 32'(done), 32'd0);
    randomize_tab();
    sync_ref();
    sweep(-1, 0, 1'b0, s);

    // Start while busy, then reset mid-EMIT.
    randomize_tab();
    sync_ref();
    s_part = 'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      wait_valid();
      s_part = misr_ref(s_part, int'(tab[r]));
      tick();
    end
    wait_valid();
    s_part = misr_ref(s_part, int'(tab[2]));
    tif.tt_ready = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sb_valid", 32'(tif.tt_valid), 32'd1);
    check("sb_index", 32'(tif.tt_index), 32'd2);
    check("sb_dut_in", 32'(dut_in), 32'd2);
    check("sb_busy", 32'(busy), 32'd1);
    check("sb_sig", 32'(signature), 32'(s_part));
    rst_n = 1'b0;
    tick();
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_aborted", 32'(aborted), 32'd0);
    check("mr_valid", 32'(tif.tt_valid), 32'd0);
    check("mr_dut_in", 32'(dut_in), 32'd0);
    check("mr_index", 32'(tif.tt_index), 32'd0);
    check("mr_data", 32'(tif.tt_data), 32'd0);
    check("mr_sig", 32'(signature), 32'hFFFF);
    rst_n = 1'b1;
    tif.tt_ready = 1'b1;
    tick();
    check("mr_idle_busy", 32'(busy), 32'd0);
    check("mr_idle_done", 32'(done), 32'd0);
    randomize_tab();
    sync_ref();
    sweep(int'($urandom_range(0, 7)), int'($urandom_range(1, 4)), 1'b0, s);

`ifdef COMB_SWEEP_EQUIV_EN
    // Reference differs only at vectors 2 and 6; then a clean run clears the flags.
    randomize_tab();
    sync_ref();
    ref_tab[2] = tab[2] ^ 4'd1;
    ref_tab[6] = tab[6] ^ 4'd2;
    sweep(-1, 0, 1'b0, s);
    check("eq_final_mm", 32'(mismatch), 32'd1);
    check("eq_final_idx", 32'(first_bad_idx), 32'd2);
    sync_ref();
    sweep(-1, 0, 1'b0, s);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
